gate_model_sequencer: RTL and testbench

GATE_MODEL_SEQUENCER -- requirements
Module: gate_model_sequencer

---
 rtl/gate_model_sequencer.sv | 135 +++++++++++++
 tb/tb_gate_model_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_model_sequencer.sv
// gate_model_sequencer
// Drives pseudo-random vectors from an 18-bit LFSR into a combinational gate
// model, waits SETTLE cycles per vector, folds each 10-bit response into a
// 16-bit MISR and compares the final signature against a golden value.
//
// Handshake: start is a level sampled only while idle; a run is accepted on
// the first rising edge that sees start=1 in IDLE. done is a one-cycle pulse
// that marks the cycle in which pass is first valid. abort cancels a running
// sequence (SETTLE/CAPTURE) on the next edge without producing done.
module gate_model_sequencer #(
    parameter int SETTLE = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] num_vec,
    input  logic [17:0] seed,
    input  logic [15:0] golden,
    output logic [17:0] dut_in,
    input  logic [9:0]  dut_out,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] signature,
    output logic [15:0] vec_cnt
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETTLE  = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t      state;
    logic [3:0]  settle_cnt;
    logic [15:0] num_vec_q;
    logic        pass_q;
    logic [15:0] misr_next;
    logic [17:0] lfsr_next;
    logic [15:0] cnt_next;

    // Next MISR, LFSR and vector count values applied in CAPTURE
    always_comb begin
        misr_next = {signature[14:0], 1'b0}
                  ^ (signature[15] ? 16'h1021 : 16'h0000)
                  ^ {6'b0, dut_out};
        lfsr_next = {dut_in[16:0], dut_in[17] ^ dut_in[10]};
        cnt_next  = vec_cnt + 16'd1;
    end

    // pass reflects the live comparison during DONE so it is valid with done,
    // and the registered result afterwards until the next accepted start
    assign pass = (state == S_DONE) ? (signature == golden) : pass_q;

    // Sequencer FSM with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            settle_cnt <= 4'd0;
            num_vec_q  <= 16'd0;
            dut_in     <= 18'd0;
            signature  <= 16'hFFFF;
            vec_cnt    <= 16'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        num_vec_q  <= num_vec;
                        dut_in     <= (seed == 18'd0) ? 18'h00001 : seed;
                        signature  <= 16'hFFFF;
                        vec_cnt    <= 16'd0;
                        pass_q     <= 1'b0;
                        settle_cnt <= 4'd0;
                        if (num_vec == 16'd0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_SETTLE;
                            busy  <= 1'b1;
                        end
                    end
                end
                S_SETTLE: begin
                    if (abort) begin
                        state  <= S_IDLE;
                        busy   <= 1'b0;
                        pass_q <= 1'b0;
                    end else if (settle_cnt == SETTLE_LAST) begin
                        state <= S_CAPTURE;
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                S_CAPTURE: begin
                    if (abort) begin
                        state  <= S_IDLE;
                        busy   <= 1'b0;
                        pass_q <= 1'b0;
                    end else begin
                        signature  <= misr_next;
                        dut_in     <= lfsr_next;
                        vec_cnt    <= cnt_next;
                        settle_cnt <= 4'd0;
                        if (cnt_next == num_vec_q) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= S_SETTLE;
                        end
                    end
                end
                S_DONE: begin
                    done   <= 1'b0;
                    pass_q <= (signature == golden);
                    state  <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_model_sequencer.sv
// tb_gate_model_sequencer
// Runs directed and randomized sequences against a behavioural model that
// precomputes the vector/signature history of each run and derives the
// per-cycle expected outputs from the cycle offset within the run.
module tb_gate_model_sequencer;

  localparam int S = 2;
  localparam int P = S + 1;  // cycles per vector

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [15:0] num_vec;
  logic [17:0] seed;
  logic [15:0] golden;
  logic [17:0] dut_in;
  logic [9:0]  dut_out;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] signature;
  logic [15:0] vec_cnt;

  logic        gm_zero;
  logic [9:0]  gm_key;

  gate_model_sequencer #(.SETTLE(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .num_vec   (num_vec),
    .seed      (seed),
    .golden    (golden),
    .dut_in    (dut_in),
    .dut_out   (dut_out),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .signature (signature),
    .vec_cnt   (vec_cnt)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- gate model ----------------
  function automatic logic [9:0] gm(input logic [17:0] x, input logic z, input logic [9:0] k);
    return z ? 10'd0 : (x[9:0] ^ x[17:8] ^ k);
  endfunction

  assign dut_out = gm(dut_in, gm_zero, gm_key);

  // ---------------- reference model ----------------
  logic [17:0] m_vec[$];  // m_vec[i]: stimulus while vector i is applied
  logic [15:0] m_sig[$];  // m_sig[i]: signature after i captures

  function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [9:0] d);
    logic [15:0] r;
    r = {s[14:0], 1'b0};
    if (s[15]) r = r ^ 16'h1021;
    return r ^ {6'b0, d};
  endfunction

  function automatic logic [17:0] lfsr_step(input logic [17:0] x);
    return {x[16:0], x[17] ^ x[10]};
  endfunction

  task automatic build_model(input logic [17:0] sd, input int n, input logic z, input logic [9:0] k);
    logic [17:0] x;
    logic [15:0] s;
    m_vec.delete();
    m_sig.delete();
    x = (sd == 18'd0) ? 18'h00001 : sd;
    s = 16'hFFFF;
    m_vec.push_back(x);
    m_sig.push_back(s);
    for (int i = 0; i < n; i++) begin
      s = misr_step(s, gm(x, z, k));
      x = lfsr_step(x);
      m_vec.push_back(x);
      m_sig.push_back(s);
    end
  endtask

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int n_done  = 0;
  int cyc     = 0;
  int done_cyc = 0;
  int start_cyc = 0;
  bit chk_en = 1'b0;

  logic        exp_busy, exp_done, exp_pass;
  logic [15:0] exp_sig, exp_cnt;
  logic [17:0] exp_din;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy",      {31'b0, busy},      {31'b0, exp_busy});
      check("done",      {31'b0, done},      {31'b0, exp_done});
      check("pass",      {31'b0, pass},      {31'b0, exp_pass});
      check("signature", {16'b0, signature}, {16'b0, exp_sig});
      check("vec_cnt",   {16'b0, vec_cnt},   {16'b0, exp_cnt});
      check("dut_in",    {14'b0, dut_in},    {14'b0, exp_din});
    end
    if (done === 1'b1) begin
      n_done++;
      done_cyc = cyc;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_reset_exp;
    exp_busy = 1'b0;
    exp_done = 1'b0;
    exp_pass = 1'b0;
    exp_sig  = 16'hFFFF;
    exp_cnt  = 16'd0;
    exp_din  = 18'd0;
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      tick();
      start = 1'b0;
      abort = 1'($urandom_range(0, 1));  // no effect in IDLE
    end
    abort = 1'b0;
  endtask

  // One run. Called just after a rising edge with the DUT idle.
  // abort_at / rst_at: cycle offset (0 = start edge) at which to cancel, -1 = never.
  task automatic run(input logic [17:0] sd, input int n, input logic [15:0] gold,
                     input bit gold_from_model, input logic z, input logic [9:0] k,
                     input int abort_at, input int rst_at, input bit noise);
    int lim;
    int v;
    lim = n * P;
    build_model(sd, n, z, k);
    if (gold_from_model) gold = m_sig[n];
    gm_zero = z;
    gm_key  = k;
    seed    = sd;
    num_vec = 16'(n);
    golden  = gold;
    abort   = 1'b0;
    start   = 1'b1;
    for (int t = 0; t <= lim; t++) begin
      tick();
      if (t == 0) start_cyc = cyc;
      start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      abort = 1'b0;
      v = t / P;
      exp_din = m_vec[v];
      exp_sig = m_sig[v];
      exp_cnt = 16'(v);
      if (t < lim) begin
        exp_busy = 1'b1;
        exp_done = 1'b0;
        exp_pass = 1'b0;
      end else begin
        exp_busy = 1'b0;
        exp_done = 1'b1;
        exp_pass = (m_sig[n] == gold);
        if (noise) abort = 1'($urandom_range(0, 1));  // no effect in DONE
      end
      if (t == abort_at) begin
        abort = 1'b1;
        start = 1'b0;
        tick();
        abort    = 1'b0;
        exp_busy = 1'b0;
        exp_done = 1'b0;
        exp_pass = 1'b0;
        return;
      end
      if (t == rst_at) begin
        start = 1'b0;
        rst_n = 1'b0;
        set_reset_exp();
        #1;
        check("rst_async_sig", {16'b0, signature}, 32'h0000FFFF);
        check("rst_async_din", {14'b0, dut_in}, 32'h0);
        check("rst_async_busy", {31'b0, busy}, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        return;
      end
    end
    tick();
    start    = 1'b0;
    abort    = 1'b0;
    exp_busy = 1'b0;
    exp_done = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    int ab;
    int rs;
    int d0;
    rst_n   = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    num_vec = 16'd0;
    seed    = 18'd0;
    golden  = 16'd0;
    gm_zero = 1'b1;
    gm_key  = 10'd0;
    set_reset_exp();
    chk_en = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    idle(2);

    // Reference run: seed 1, three vectors, zero response
    run(18'h00001, 3, 16'h8F1F, 1'b0, 1'b1, 10'd0, -1, -1, 1'b0);
    // done rises 9 edges after the start edge, i.e. in cycle k+10
    check("latency_3vec", done_cyc - start_cyc, 9);
    check("model_vec0", {14'b0, m_vec[0]}, 32'h1);
    check("model_vec1", {14'b0, m_vec[1]}, 32'h2);
    check("model_vec2", {14'b0, m_vec[2]}, 32'h4);
    check("model_sig", {16'b0, m_sig[3]}, 32'h8F1F);
    check("ref_sig", {16'b0, signature}, 32'h8F1F);
    check("ref_pass", {31'b0, pass}, 32'h1);
    check("ref_cnt", {16'b0, vec_cnt}, 32'h3);
    idle(3);

    // Same run, wrong golden
    run(18'h00001, 3, 16'h1234, 1'b0, 1'b1, 10'd0, -1, -1, 1'b0);
    check("badgold_pass", {31'b0, pass}, 32'h0);
    check("badgold_sig", {16'b0, signature}, 32'h8F1F);
    idle(2);

    // Zero-length runs
    run(18'h00005, 0, 16'hFFFF, 1'b0, 1'b1, 10'd0, -1, -1, 1'b0);
    check("latency_0vec", done_cyc - start_cyc, 0);
    check("zero_pass", {31'b0, pass}, 32'h1);
    run(18'h00007, 0, 16'h0001, 1'b0, 1'b1, 10'd0, -1, -1, 1'b0);
    check("zero_fail_pass", {31'b0, pass}, 32'h0);
    check("zero_sig", {16'b0, signature}, 32'h0000FFFF);
    idle(2);

    // Seed 0 with start noise while busy
    d0 = n_done;
    run(18'h00000, 3, 16'h8F1F, 1'b0, 1'b1, 10'd0, -1, -1, 1'b1);
    check("seed0_pass", {31'b0, pass}, 32'h1);
    check("single_done", n_done - d0, 1);
    idle(2);

    // Abort in second SETTLE
    d0 = n_done;
    run(18'h00001, 3, 16'h8F1F, 1'b0, 1'b1, 10'd0, P + 1, -1, 1'b0);
    check("abort_cnt", {16'b0, vec_cnt}, 32'h1);
    check("abort_busy", {31'b0, busy}, 32'h0);
    check("abort_din", {14'b0, dut_in}, 32'h2);
    idle(3);
    check("abort_no_done", n_done - d0, 0);

    // Reset during first CAPTURE, then a fresh run accepted right away
    run(18'h00001, 3, 16'h8F1F, 1'b0, 1'b1, 10'd0, -1, S, 1'b0);
    run(18'h00001, 3, 16'h8F1F, 1'b0, 1'b1, 10'd0, -1, -1, 1'b0);
    check("post_rst_sig", {16'b0, signature}, 32'h8F1F);
    check("post_rst_pass", {31'b0, pass}, 32'h1);
    idle(1);

    // Randomized runs
    for (int r = 0; r < 30; r++) begin
      n  = $urandom_range(0, 8);
      ab = -1;
      rs = -1;
      if (n > 0 && $urandom_range(0, 3) == 0) ab = $urandom_range(0, n * P - 1);
      else if (n > 0 && $urandom_range(0, 7) == 0) rs = $urandom_range(0, n * P - 1);
      run(18'($urandom), n, 16'($urandom), 1'($urandom_range(0, 1)), 1'b0,
          10'($urandom), ab, rs, 1'b1);
      idle($urandom_range(0, 3));
    end

    // One longer run
    run(18'($urandom), 300, 16'd0, 1'b1, 1'b0, 10'($urandom), -1, -1, 1'b1);
    check("long_cnt", {16'b0, vec_cnt}, 300);
    check("long_pass", {31'b0, pass}, 32'h1);
    idle(2);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
